// File: rtl/platform_field_pkg.sv
// Shared types and default playfield constants for the platform manager.
package platform_pkg;

  typedef enum logic [1:0] {
    STATIC    = 2'd0,
    MOVING    = 2'd1,
    BREAKABLE = 2'd2
  } plat_kind_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } sweep_state_t;

  localparam int DEF_N_PLAT    = 8;
  localparam int DEF_W         = 10;
  localparam int DEF_SCREEN_W  = 320;
  localparam int DEF_SCREEN_H  = 480;
  localparam int DEF_PLAT_HALF = 20;
  localparam int DEF_ROW_GAP   = 60;
  localparam int DEF_H_SPEED   = 1;
  localparam int RESET_X_MULT  = 73;

endpackage

// File: rtl/platform_field_if.sv
// Bus between the scroll controller (master) and the platform manager (slave).
interface platform_field_if #(
  parameter int N_PLAT = 8,
  parameter int W      = 10
) ();
  localparam int IW = $clog2(N_PLAT);

  logic [W-1:0]              scroll_dy;
  logic                      break_req;
  logic [IW-1:0]             break_idx;
  logic [N_PLAT-1:0][W-1:0]  plat_x;
  logic [N_PLAT-1:0][W-1:0]  plat_y;
  logic [N_PLAT-1:0][1:0]    plat_kind;
  logic [N_PLAT-1:0]         plat_valid;
  logic                      busy;
  logic                      update_done;
  logic                      overrun;

  modport master (
    output scroll_dy, break_req, break_idx,
    input  plat_x, plat_y, plat_kind, plat_valid, busy, update_done, overrun
  );

  modport slave (
    input  scroll_dy, break_req, break_idx,
    output plat_x, plat_y, plat_kind, plat_valid, busy, update_done, overrun
  );
endinterface

// File: rtl/platform_field_lfsr16.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) that advances only when enabled.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  output logic [15:0] o_q
);
  logic [15:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_q <= SEED;
    else if (i_en) r_q <= {r_q[14:0], r_q[15] ^ r_q[13] ^ r_q[12] ^ r_q[10]};
  end

  assign o_q = r_q;
endmodule

// File: rtl/platform_field.sv
// Platform manager: once per frame tick, sweeps one platform per clock applying
// horizontal motion, camera scroll and LFSR-driven respawn.
module platform_field
  import platform_pkg::*;
#(
  parameter int          N_PLAT    = DEF_N_PLAT,
  parameter int          W         = DEF_W,
  parameter int          SCREEN_W  = DEF_SCREEN_W,
  parameter int          SCREEN_H  = DEF_SCREEN_H,
  parameter int          PLAT_HALF = DEF_PLAT_HALF,
  parameter int          ROW_GAP   = DEF_ROW_GAP,
  parameter int          H_SPEED   = DEF_H_SPEED,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_clk,
  platform_field_if.slave  bus
);
  localparam int X_MIN  = PLAT_HALF;
  localparam int X_MAX  = SCREEN_W - 1 - PLAT_HALF;
  localparam int X_SPAN = X_MAX - X_MIN + 1;
  localparam int RBITS  = $clog2(X_SPAN);
  localparam int IW     = $clog2(N_PLAT);

  sweep_state_t      r_state, w_next;
  logic [2:0]        r_sync;
  logic              w_tick, r_pending, w_pending_n, w_overrun, w_start;
  logic [IW-1:0]     r_idx;
  logic [W-1:0]      r_dy;
  logic [W-1:0]      r_x [N_PLAT];
  logic [W-1:0]      r_y [N_PLAT];
  plat_kind_t        r_kind [N_PLAT];
  logic [N_PLAT-1:0] r_valid, r_dir;

  logic [15:0]       w_lfsr;
  logic              w_lfsr_en, w_unused_lfsr;
  logic [W-1:0]      w_cur_x, w_x_n, w_y_n, w_spawn_x;
  logic              w_dir_n, w_respawn, w_brk_ok;
  logic [W:0]        w_ysum;
  logic [RBITS-1:0]  w_r, w_rx;
  plat_kind_t        w_spawn_kind;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (Clk),
    .rst  (Reset),
    .i_en (w_lfsr_en),
    .o_q  (w_lfsr)
  );
  assign w_unused_lfsr = ^w_lfsr;

  // r_sync[1:0] is the synchroniser; r_sync[2] holds the previous value for edge detect.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_sync <= '0;
    else       r_sync <= {r_sync[1:0], frame_clk};
  end
  assign w_tick = r_sync[1] & ~r_sync[2];

  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_overrun   = 1'b0;
    w_pending_n = r_pending;
    case (r_state)
      S_IDLE: begin
        if (w_tick || r_pending) begin
          w_next  = S_SWEEP;
          w_start = 1'b1;
        end
      end
      S_SWEEP: if (r_idx == IW'(N_PLAT - 1)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_tick && r_pending)            w_overrun   = 1'b1;
    else if (w_tick && r_state != S_IDLE) w_pending_n = 1'b1;
    // Leaving IDLE always consumes the pending request.
    if (r_state == S_IDLE)              w_pending_n = 1'b0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_pending <= 1'b0;
      r_idx     <= '0;
      r_dy      <= '0;
    end else begin
      r_state   <= w_next;
      r_pending <= w_pending_n;
      if (w_start) begin
        r_idx <= '0;
        r_dy  <= bus.scroll_dy;
      end else if (r_state == S_SWEEP) begin
        r_idx <= r_idx + IW'(1);
      end
    end
  end

  always_comb begin
    w_cur_x = r_x[r_idx];
    w_x_n   = w_cur_x;
    w_dir_n = r_dir[r_idx];
    if (r_kind[r_idx] == MOVING) begin
      if (r_dir[r_idx]) begin
        if ({1'b0, w_cur_x} + (W+1)'(H_SPEED) >= (W+1)'(X_MAX)) begin
          w_x_n   = W'(X_MAX);
          w_dir_n = 1'b0;
        end else begin
          w_x_n = w_cur_x + W'(H_SPEED);
        end
      end else begin
        if ({1'b0, w_cur_x} <= (W+1)'(X_MIN + H_SPEED)) begin
          w_x_n   = W'(X_MIN);
          w_dir_n = 1'b1;
        end else begin
          w_x_n = w_cur_x - W'(H_SPEED);
        end
      end
    end

    w_ysum    = {1'b0, r_y[r_idx]} + {1'b0, r_dy};
    w_respawn = w_ysum >= (W+1)'(SCREEN_H);
    w_y_n     = w_respawn ? W'(w_ysum - (W+1)'(SCREEN_H)) : w_ysum[W-1:0];

    w_r       = w_lfsr[RBITS-1:0];
    w_rx      = (w_r >= RBITS'(X_SPAN)) ? w_r - RBITS'(X_SPAN) : w_r;
    w_spawn_x = W'(X_MIN) + W'(w_rx);
    case (w_lfsr[15:14])
      2'b00:   w_spawn_kind = BREAKABLE;
      2'b01:   w_spawn_kind = MOVING;
      default: w_spawn_kind = STATIC;
    endcase

    w_lfsr_en = (r_state == S_SWEEP) && w_respawn;
    w_brk_ok  = bus.break_req && ({1'b0, bus.break_idx} < (IW+1)'(N_PLAT));
  end

  // Break is written first so a same-cycle respawn of that index overrides it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < N_PLAT; i++) begin
        r_y[i]    <= W'(i * ROW_GAP + ROW_GAP / 2);
        r_x[i]    <= W'(X_MIN + (i * RESET_X_MULT) % X_SPAN);
        r_kind[i] <= (i % 2 == 1) ? MOVING : STATIC;
      end
      r_valid <= '1;
      r_dir   <= '1;
    end else begin
      if (w_brk_ok) r_valid[bus.break_idx] <= 1'b0;
      if (r_state == S_SWEEP) begin
        r_y[r_idx] <= w_y_n;
        if (w_respawn) begin
          r_x[r_idx]     <= w_spawn_x;
          r_kind[r_idx]  <= w_spawn_kind;
          r_valid[r_idx] <= 1'b1;
          r_dir[r_idx]   <= 1'b1;
        end else begin
          r_x[r_idx]   <= w_x_n;
          r_dir[r_idx] <= w_dir_n;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_PLAT; i++) begin
      bus.plat_x[i]    = r_x[i];
      bus.plat_y[i]    = r_y[i];
      bus.plat_kind[i] = r_kind[i];
    end
    bus.plat_valid  = r_valid;
    bus.busy        = (r_state != S_IDLE);
    bus.update_done = (r_state == S_DONE);
    bus.overrun     = w_overrun;
  end
endmodule

// File: tb/tb_platform_field.sv
// Directed bench for platform_field with a frame-level reference model.
module tb_platform_field;
  localparam int N = 8;

  logic Clk, Reset, frame_clk;
  platform_field_if #(.N_PLAT(N), .W(10)) bus ();

  platform_field #(.N_PLAT(N), .W(10)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .bus       (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int passes = 0, total = 0;
  int done_cnt = 0, ovr_cnt = 0;
  bit cmp_en = 0;

  int m_x[N], m_y[N], m_kind[N], m_valid[N], m_dir[N];
  logic [15:0] m_lfsr;
  int m_dy;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_y[i] = i * 60 + 30;
      m_x[i] = 20 + (i * 73) % 280;
      m_kind[i] = i % 2;
      m_valid[i] = 1;
      m_dir[i] = 1;
    end
    m_lfsr = 16'hACE1;
  endtask

  // One whole frame: every platform moves, scrolls, and possibly respawns in index order.
  task automatic model_frame();
    int r;
    for (int i = 0; i < N; i++) begin
      if (m_kind[i] == 1) begin
        if (m_dir[i] == 1) begin
          m_x[i] = (m_x[i] + 1 > 299) ? 299 : m_x[i] + 1;
          if (m_x[i] == 299) m_dir[i] = 0;
        end else begin
          m_x[i] = (m_x[i] - 1 < 20) ? 20 : m_x[i] - 1;
          if (m_x[i] == 20) m_dir[i] = 1;
        end
      end
      m_y[i] = m_y[i] + m_dy;
      if (m_y[i] >= 480) begin
        m_y[i] = m_y[i] - 480;
        r = int'(m_lfsr) % 512;
        if (r >= 280) r = r - 280;
        m_x[i] = 20 + r;
        case (int'(m_lfsr) / 16384)
          0: m_kind[i] = 2;
          1: m_kind[i] = 1;
          default: m_kind[i] = 0;
        endcase
        m_valid[i] = 1;
        m_dir[i] = 1;
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      end
    end
  endtask

  always @(negedge Clk) begin
    if (!Reset && bus.update_done) begin
      done_cnt++;
      model_frame();
    end
    if (!Reset && bus.overrun) ovr_cnt++;
  end

  always @(negedge Clk) begin
    if (cmp_en && !Reset && !bus.busy) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("x[%0d]", i), int'(bus.plat_x[i]), m_x[i]);
        chk($sformatf("y[%0d]", i), int'(bus.plat_y[i]), m_y[i]);
        chk($sformatf("kind[%0d]", i), int'(bus.plat_kind[i]), m_kind[i]);
        chk($sformatf("valid[%0d]", i), int'(bus.plat_valid[i]), m_valid[i]);
      end
      chk("idle_update_done", int'(bus.update_done), 0);
      chk("idle_overrun", int'(bus.overrun), 0);
    end
  end

  task automatic wait_busy();
    int n = 0;
    while (!bus.busy && n < 20) begin @(negedge Clk); n++; end
    if (!bus.busy) chk("busy_timeout", 0, 1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.update_done && n < 40) begin @(negedge Clk); n++; end
    if (!bus.update_done) chk("done_timeout", 0, 1);
  endtask

  task automatic tick_frame(input int dy, input bit chk_lat);
    int n;
    @(posedge Clk); #1; bus.scroll_dy = 10'(dy); m_dy = dy; frame_clk = 1'b1;
    @(posedge Clk); #1; frame_clk = 1'b0;
    wait_busy();
    wait_done(n);
    if (chk_lat) chk("sweep_latency", n, N);
    @(negedge Clk);
  endtask

  task automatic brk(input int idx);
    @(posedge Clk); #1; bus.break_req = 1'b1; bus.break_idx = 3'(idx);
    @(posedge Clk); #1; bus.break_req = 1'b0; m_valid[idx] = 0;
  endtask

  initial begin
    int n, ov0, d0, seen;
    Reset = 1'b1; frame_clk = 1'b0;
    bus.scroll_dy = '0; bus.break_req = 1'b0; bus.break_idx = '0;
    model_reset(); m_dy = 0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    cmp_en = 1;
    @(negedge Clk);
    chk("rst_y0", int'(bus.plat_y[0]), 30);
    chk("rst_y7", int'(bus.plat_y[7]), 450);
    chk("rst_x1", int'(bus.plat_x[1]), 93);
    chk("rst_kind", int'({bus.plat_kind[1], bus.plat_kind[0]}), 4);
    chk("rst_valid", int'(bus.plat_valid), 8'hFF);
    chk("rst_busy", int'(bus.busy), 0);

    tick_frame(0, 1);
    chk("dy0_x1", int'(bus.plat_x[1]), 94);
    chk("dy0_x0_static", int'(bus.plat_x[0]), 20);

    tick_frame(40, 1);
    chk("dy40_y7_respawn", int'(bus.plat_y[7]), 10);
    chk("dy40_x7_lfsr", int'(bus.plat_x[7]), 245);
    chk("dy40_kind7", int'(bus.plat_kind[7]), 0);
    chk("dy40_y0", int'(bus.plat_y[0]), 70);

    brk(3);
    chk("idle_break3", int'(bus.plat_valid), 8'hF7);

    // Breaks landing in the update cycles of idx 2 (no respawn) and idx 6 (respawn).
    @(posedge Clk); #1; bus.scroll_dy = 10'd50; m_dy = 50; frame_clk = 1'b1;
    @(posedge Clk); #1; frame_clk = 1'b0;
    wait_busy();
    repeat (2) @(posedge Clk);
    #1; bus.break_req = 1'b1; bus.break_idx = 3'd2; m_valid[2] = 0;
    @(posedge Clk); #1; bus.break_req = 1'b0;
    repeat (3) @(posedge Clk);
    #1; bus.break_req = 1'b1; bus.break_idx = 3'd6; m_valid[6] = 0;
    @(posedge Clk); #1; bus.break_req = 1'b0;
    wait_done(n);
    @(negedge Clk);
    chk("sweep_break_valid", int'(bus.plat_valid), 8'hF3);
    chk("dy50_y6_respawn", int'(bus.plat_y[6]), 0);

    ov0 = ovr_cnt; d0 = done_cnt;
    bus.scroll_dy = '0; m_dy = 0;
    repeat (3) begin
      @(posedge Clk); #1; frame_clk = 1'b1;
      @(posedge Clk); #1; frame_clk = 1'b0;
    end
    n = 0;
    while (done_cnt < d0 + 2 && n < 80) begin @(negedge Clk); n++; end
    @(negedge Clk);
    chk("overrun_pulses", ovr_cnt - ov0, 1);
    chk("sweeps_with_pending", done_cnt - d0, 2);

    n = 0;
    while (m_x[3] != 299 && n < 100) begin tick_frame(0, 0); n++; end
    chk("bounce_x3_max", int'(bus.plat_x[3]), 299);
    tick_frame(0, 0);
    chk("bounce_x3_back", int'(bus.plat_x[3]), 298);

    repeat (2) begin
      @(posedge Clk); #1; frame_clk = 1'b1;
      @(posedge Clk); #1; frame_clk = 1'b0;
    end
    wait_busy();
    repeat (3) @(posedge Clk);
    #2; Reset = 1'b1; model_reset();
    #1;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_y7", int'(bus.plat_y[7]), 450);
    chk("midrst_x3", int'(bus.plat_x[3]), 239);
    chk("midrst_valid", int'(bus.plat_valid), 8'hFF);
    @(posedge Clk); #1; Reset = 1'b0;
    seen = 0;
    repeat (20) begin @(negedge Clk); if (bus.busy) seen++; end
    chk("pending_cleared", seen, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/platform_field.md
# platform_field

Parametrised platform manager for the Doodle Jump playfield. It holds N_PLAT platforms and, once per frame tick, sweeps them one per Clk cycle. The sweep applies horizontal motion, applies the vertical scroll requested by the player/camera logic, and respawns platforms that fall off the bottom at an LFSR-chosen X with an LFSR-chosen kind. It sits between the player/scroll controller (scroll_dy, break requests) and the sprite renderer (position/kind/valid arrays).

## Interface
- N_PLAT, 8, number of platforms (2..32)
- W, 10, coordinate width
- SCREEN_W, 320, playfield width in pixels
- SCREEN_H, 480, playfield height in pixels
- PLAT_HALF, 20, platform half-width; X range is [X_MIN=PLAT_HALF, X_MAX=SCREEN_W-1-PLAT_HALF]
- ROW_GAP, 60, vertical spacing at reset
- H_SPEED, 1, pixels per frame for MOVING platforms
- LFSR_SEED, 16'hACE1, LFSR reset value (nonzero)

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset  in  1  asynchronous, active-high
- frame_clk  in  1  ~60 Hz frame strobe, asynchronous to Clk
- scroll_dy  in  W  downward scroll for this frame, sampled at tick, must be < SCREEN_H
- break_req  in  1  one-cycle request to mark a platform broken
- break_idx  in  clog2(N_PLAT)  platform index for break_req
- plat_x  out  N_PLAT×W  platform centre X
- plat_y  out  N_PLAT×W  platform Y (0 = top, increasing downward)
- plat_kind  out  N_PLAT×2  STATIC=0, MOVING=1, BREAKABLE=2
- plat_valid  out  N_PLAT  platform drawable/landable
- busy  out  1  sweep in progress
- update_done  out  1  one-cycle pulse at end of sweep
- overrun  out  1  one-cycle pulse when a tick is dropped

## Operation
- Reset values: plat_y[i]=i*ROW_GAP+ROW_GAP/2; plat_x[i]=X_MIN+((i*73) mod X_SPAN), where X_SPAN=X_MAX-X_MIN+1; kind[i]=MOVING if i is odd, else STATIC; valid=all 1; dir=all +1; LFSR=LFSR_SEED; state IDLE; busy/update_done/overrun=0.
- frame_clk goes through a 2-flop synchroniser. A rising edge generates tick.
- FSM IDLE → SWEEP → DONE → IDLE.
  - IDLE + tick (or pending set): latch scroll_dy into dy_q, set idx=0, go to SWEEP.
  - SWEEP: update platform idx. After idx=N_PLAT-1, go to DONE.
  - DONE: update_done=1. Return to IDLE.
- A tick in SWEEP or DONE sets pending. A tick while pending is already set is dropped and pulses overrun.
- Per-platform update, all in one cycle:
  1. If MOVING and dir=+1: x' = min(x+H_SPEED, X_MAX), and dir flips to −1 when x' = X_MAX. The dir=−1 case mirrors this against X_MIN. Other kinds keep x.
  2. Compute y_sum = y + dy_q in W+1 bits.
  3. If y_sum ≥ SCREEN_H, respawn:
     - y = y_sum − SCREEN_H.
     - x = X_MIN + r, where r = LFSR[RBITS-1:0] with RBITS=clog2(X_SPAN), minus X_SPAN if r ≥ X_SPAN.
     - kind from LFSR[15:14]: 00 gives BREAKABLE, 01 gives MOVING, otherwise STATIC.
     - valid=1, dir=+1.
     - LFSR steps once.
  4. Otherwise y = y_sum[W-1:0].
- LFSR steps only on respawn.
- break_req clears valid[break_idx] at the next edge in any state.
  - If it coincides with a respawn of the same index, the respawn wins (valid=1).
  - If it coincides with a non-respawn update of the same index, valid=0.
  - break_idx ≥ N_PLAT is ignored.
- Invalid platforms still move, scroll and respawn.

## Timing
- The tick is seen at cycle T. The first SWEEP cycle is T+1. Platform k's registers update at the end of cycle T+1+k.
- update_done is high in cycle T+1+N_PLAT. IDLE resumes at T+2+N_PLAT.
- busy is high during SWEEP and DONE.
- Outputs are coherent only after update_done. The renderer samples them in IDLE.
- Reset asserted mid-sweep returns all state to its reset values immediately (asynchronous) and clears pending.

## Structure
- platform_pkg holds:
  - the plat_kind_t enum (STATIC, MOVING, BREAKABLE)
  - the default screen constants
  - the reset-X multiplier 73
- Sub-module lfsr16: Fibonacci polynomial x^16+x^14+x^13+x^11+1, with an enable input, a seed parameter, and async reset.
- X_SPAN and RBITS are localparams.

## Test plan
- Reset, default params → y=30,90,…,450; x[1]=93; kind pattern S,M,S,M…; valid=8'hFF; busy=0.
- One tick with scroll_dy=0 → update_done at T+9; MOVING x[1] 93→94; STATIC x unchanged; LFSR unchanged.
- One tick with scroll_dy=40 → plat 7: y 450→490≥480, respawns to y=10 with LFSR-derived x in [20,299]; LFSR steps once; others +40.
- MOVING platform forced to x=299, dir +1 → next sweep x=299, dir −1; following sweep x=298.
- break_req idx=3 while IDLE → valid[3]=0 next cycle. break_req on respawn index in its SWEEP cycle → valid=1.
- Three ticks inside one sweep → one pending serviced (second sweep follows DONE), one overrun pulse. Reset mid-sweep → reset values next cycle.
